// File: rtl/vend_dispense_ctrl.sv
// Vending dispense controller: coin credit, vend/change sequencing, and the
// 4-phase changeState / cancelled handshakes with the selector FSM.
module vend_dispense_ctrl #(
  parameter int unsigned CREDIT_W        = 8,
  parameter int unsigned MAX_CREDIT      = 255,
  parameter int unsigned DISPENSE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          state,
  input  logic [3:0]          index,
  input  logic [CREDIT_W-1:0] price,
  input  logic                coin_valid,
  input  logic [CREDIT_W-1:0] coin_value,
  input  logic                cancelled,
  input  logic                changeStateDone,
  output logic                changeState,
  output logic                cancelledDone,
  output logic                dispense,
  output logic [3:0]          dispense_index,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amount,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  localparam int unsigned CNT_W = (DISPENSE_CYCLES > 1) ? $clog2(DISPENSE_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VEND,
    S_CHANGE,
    S_HS_REQ,
    S_HS_REL,
    S_REFUND,
    S_CAN_ACK
  } st_t;

  st_t                 cur, nxt;
  logic [CNT_W-1:0]    cnt_q;
  logic [CREDIT_W-1:0] credit_q;
  logic [CREDIT_W-1:0] price_q;
  logic [3:0]          index_q;
  logic                coin_reject_q;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_ok;
  logic                vend_go;
  logic                cnt_done;

  // Sum carried one bit wider so an overflowing coin is detected, not wrapped.
  assign coin_sum = {1'b0, credit_q} + {1'b0, coin_value};
  assign coin_ok  = coin_valid && (cur == S_IDLE) &&
                    (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));
  // Decision uses registered (pre-coin) credit, so a same-cycle coin never funds it.
  assign vend_go  = (state == 2'b01) && (credit_q >= price);
  assign cnt_done = (cnt_q == CNT_W'(DISPENSE_CYCLES - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur <= S_IDLE;
    else        cur <= nxt;
  end

  // Next-state logic; cancel has priority over a vend in IDLE.
  always_comb begin
    nxt = cur;
    unique case (cur)
      S_IDLE: begin
        if (cancelled)    nxt = S_REFUND;
        else if (vend_go) nxt = S_VEND;
      end
      S_VEND:    if (cnt_done) nxt = S_CHANGE;
      S_CHANGE:  nxt = S_HS_REQ;
      S_HS_REQ:  if (changeStateDone) nxt = S_HS_REL;
      S_HS_REL:  if (!changeStateDone) nxt = S_IDLE;
      S_REFUND:  nxt = S_CAN_ACK;
      S_CAN_ACK: if (!cancelled) nxt = S_IDLE;
      default:   nxt = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    changeState   = (cur == S_HS_REQ);
    cancelledDone = (cur == S_CAN_ACK);
    dispense      = (cur == S_VEND);
    change_valid  = (cur == S_CHANGE) || (cur == S_REFUND);
    busy          = (cur != S_IDLE);
    change_amount = '0;
    if (cur == S_CHANGE)      change_amount = credit_q - price_q;
    else if (cur == S_REFUND) change_amount = credit_q;
  end

  // Credit accumulation, coin rejection, vend latching and dispense timing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_q      <= '0;
      price_q       <= '0;
      index_q       <= '0;
      coin_reject_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      if (cur == S_CHANGE || cur == S_REFUND) credit_q <= '0;
      else if (coin_ok)                       credit_q <= coin_sum[CREDIT_W-1:0];
      coin_reject_q <= coin_valid && !coin_ok;
      if (cur == S_IDLE && !cancelled && vend_go) begin
        price_q <= price;
        index_q <= index;
      end
      cnt_q <= (cur == S_VEND && !cnt_done) ? cnt_q + 1'b1 : '0;
    end
  end

  assign credit         = credit_q;
  assign coin_reject    = coin_reject_q;
  assign dispense_index = index_q;

endmodule
